ysyx_24070016_ifu: RTL and testbench

//  Instruction fetch stage, directly upstream of the decode stage. Owns the PC.

---
 rtl/ysyx_24070016_ifu_pkg.sv | 16 +
 rtl/ysyx_24070016_ifu_pc.sv | 42 ++++
 rtl/ysyx_24070016_ifu.sv | 146 ++++++++++++++
 tb/tb_ysyx_24070016_ifu.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24070016_ifu_pkg.sv
// Shared definitions for the ysyx_24070016 instruction fetch unit:
// datapath width, reset fetch address and FSM state encodings.
package ysyx_24070016_ifu_pkg;

    localparam int          IFU_XLEN     = 32;
    localparam logic [31:0] IFU_RESET_PC = 32'h8000_0000;

    typedef enum logic [2:0] {
        IFU_IDLE = 3'd0,
        IFU_REQ  = 3'd1,
        IFU_WAIT = 3'd2,
        IFU_OUT  = 3'd3,
        IFU_HALT = 3'd4
    } ifu_state_e;

endpackage

// File: rtl/ysyx_24070016_ifu_pc.sv
// PC register for the IFU: holds the next fetch address, advances by 4 after a
// delivered fetch and takes word-aligned redirects with priority.
module ysyx_24070016_ifu_pc #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = 32'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            seq_en_i,
    input  logic [XLEN-1:0] seq_base_i,
    input  logic            redir_en_i,
    input  logic [XLEN-1:0] redir_pc_i,
    output logic [XLEN-1:0] pc_next_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] alignedRedir;

    assign alignedRedir = redir_pc_i & ~XLEN'(3);

    // Redirect beats the sequential step; the add wraps naturally at 2^XLEN.
    always_comb begin
        pc_d = pc_q;
        if (redir_en_i) begin
            pc_d = alignedRedir;
        end else if (seq_en_i) begin
            pc_d = seq_base_i + XLEN'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_next_o = pc_d;

endmodule

// File: rtl/ysyx_24070016_ifu.sv
// Instruction fetch stage: one outstanding fetch on the imem port, a single
// output slot towards decode, redirect kill handling and sticky halt.
module ysyx_24070016_ifu
    import ysyx_24070016_ifu_pkg::*;
#(
    parameter int               XLEN     = IFU_XLEN,
    parameter logic [XLEN-1:0]  RESET_PC = IFU_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    output logic            imem_rsp_ready,
    input  logic [31:0]     imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt
);

    ifu_state_e      state_q, state_d;
    logic            kill_q, kill_d;
    logic            halted_q, halted_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic [31:0]     inst_q, inst_d;
    logic [XLEN-1:0] inst_pc_q, inst_pc_d;

    logic            redirActive;
    logic            haltNow;
    logic            seqEn;
    logic [XLEN-1:0] pcNext;

    assign redirActive = redirect_valid &&
                         (state_q == IFU_REQ || state_q == IFU_WAIT || state_q == IFU_OUT);
    assign haltNow     = halted_q | halt;

    ysyx_24070016_ifu_pc #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .rst        (rst),
        .seq_en_i   (seqEn),
        .seq_base_i (req_addr_q),
        .redir_en_i (redirActive),
        .redir_pc_i (redirect_pc),
        .pc_next_o  (pcNext)
    );

    // Entering REQ always latches pcNext so a same-cycle redirect is fetched directly.
    always_comb begin
        state_d    = state_q;
        kill_d     = kill_q;
        halted_d   = halted_q | halt;
        req_addr_d = req_addr_q;
        inst_d     = inst_q;
        inst_pc_d  = inst_pc_q;
        seqEn      = 1'b0;

        case (state_q)
            IFU_IDLE: begin
                if (haltNow) begin
                    state_d = IFU_HALT;
                end else begin
                    state_d    = IFU_REQ;
                    req_addr_d = pcNext;
                end
            end
            IFU_REQ: begin
                if (redirect_valid) begin
                    kill_d = 1'b1;
                end
                if (imem_req_ready) begin
                    state_d = IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (imem_rsp_valid) begin
                    kill_d = 1'b0;
                    if (kill_q || redirect_valid) begin
                        if (haltNow) begin
                            state_d = IFU_HALT;
                        end else begin
                            state_d    = IFU_REQ;
                            req_addr_d = pcNext;
                        end
                    end else begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = req_addr_q;
                        seqEn     = 1'b1;
                        state_d   = IFU_OUT;
                    end
                end else if (redirect_valid) begin
                    kill_d = 1'b1;
                end
            end
            IFU_OUT: begin
                if (redirect_valid || inst_ready) begin
                    if (haltNow) begin
                        state_d = IFU_HALT;
                    end else begin
                        state_d    = IFU_REQ;
                        req_addr_d = pcNext;
                    end
                end
            end
            IFU_HALT: begin
                state_d = IFU_HALT;
            end
            default: begin
                state_d = IFU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IFU_IDLE;
            kill_q     <= 1'b0;
            halted_q   <= 1'b0;
            req_addr_q <= '0;
            inst_q     <= '0;
            inst_pc_q  <= '0;
        end else begin
            state_q    <= state_d;
            kill_q     <= kill_d;
            halted_q   <= halted_d;
            req_addr_q <= req_addr_d;
            inst_q     <= inst_d;
            inst_pc_q  <= inst_pc_d;
        end
    end

    assign imem_req_valid = (state_q == IFU_REQ);
    assign imem_rsp_ready = (state_q == IFU_WAIT);
    assign inst_valid     = (state_q == IFU_OUT);
    assign imem_req_addr  = req_addr_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;

endmodule

// File: tb/tb_ysyx_24070016_ifu.sv
// Scoreboard bench for the IFU: directed scenarios push expected fetch addresses
// and delivered PCs; a monitor pops and compares on every handshake.
module tb_ysyx_24070016_ifu;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;

    int          nVectors;
    int          nMiscompares;
    int          deliveredCount;
    int          cycCount;
    int          rspDelay;
    int          deliverCycle[$];
    logic [31:0] expReqQ[$];
    logic [31:0] expInstQ[$];

    ysyx_24070016_ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_ready (imem_rsp_ready),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cycCount = 0;
        forever begin
            @(posedge clk);
            cycCount++;
        end
    end

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic reportTimeout(input string name, input bit expired);
        nVectors++;
        if (expired) begin
            nMiscompares++;
            $display("[TB] FAIL %s: bound expired, got no event, expected event", name);
        end
    endtask

    task automatic applyStimulus(input bit memRdy, input bit instRdy, input bit redir,
                                 input logic [31:0] redirPc, input bit haltIn);
        imem_req_ready = memRdy;
        inst_ready     = instRdy;
        redirect_valid = redir;
        redirect_pc    = redirPc;
        halt           = haltIn;
    endtask

    task automatic waitRspReady(input string name);
        bit expired = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (imem_rsp_ready) begin
                expired = 1'b0;
                break;
            end
        end
        reportTimeout(name, expired);
    endtask

    task automatic waitInstValid(input string name);
        bit expired = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (inst_valid) begin
                expired = 1'b0;
                break;
            end
        end
        reportTimeout(name, expired);
    endtask

    // Lets memory accept until decode has taken `target` instructions, then parks the IFU in REQ.
    task automatic streamUntil(input int target, input string name);
        bit expired = 1'b1;
        imem_req_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (deliveredCount >= target) begin
                expired = 1'b0;
                break;
            end
        end
        imem_req_ready = 1'b0;
        reportTimeout(name, expired);
    endtask

    // Memory model: samples handshakes mid-cycle, answers rspDelay cycles after acceptance.
    initial begin
        bit          reqFire, rspFire, rstS, pendActive;
        int          pendCnt;
        logic [31:0] addrS, pendAddr;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        pendActive     = 1'b0;
        pendCnt        = 0;
        pendAddr       = '0;
        forever begin
            @(negedge clk);
            reqFire = imem_req_valid && imem_req_ready;
            rspFire = imem_rsp_valid && imem_rsp_ready;
            addrS   = imem_req_addr;
            rstS    = rst;
            @(posedge clk); #1;
            if (rstS) begin
                imem_rsp_valid = 1'b0;
                pendActive     = 1'b0;
            end else begin
                if (rspFire) imem_rsp_valid = 1'b0;
                if (pendActive) begin
                    if (pendCnt > 1) begin
                        pendCnt--;
                    end else begin
                        pendActive     = 1'b0;
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = memWord(pendAddr);
                    end
                end
                if (reqFire) begin
                    if (rspDelay == 0) begin
                        imem_rsp_valid = 1'b1;
                        imem_rsp_data  = memWord(addrS);
                    end else begin
                        pendActive = 1'b1;
                        pendCnt    = rspDelay;
                        pendAddr   = addrS;
                    end
                end
            end
        end
    end

    // Monitor: every request and delivery handshake must match the head of its queue.
    initial begin
        logic [31:0] expPc;
        forever begin
            @(negedge clk);
            if (imem_req_valid && imem_req_ready) begin
                if (expReqQ.size() == 0) begin
                    nVectors++;
                    nMiscompares++;
                    $display("[TB] FAIL unexpected_req: got addr %h, expected no request", imem_req_addr);
                end else begin
                    checkOutput("req_addr", imem_req_addr, expReqQ.pop_front());
                end
            end
            if (inst_valid && inst_ready) begin
                deliverCycle.push_back(cycCount);
                deliveredCount++;
                if (expInstQ.size() == 0) begin
                    nVectors++;
                    nMiscompares++;
                    $display("[TB] FAIL unexpected_inst: got pc %h, expected no delivery", inst_pc);
                end else begin
                    expPc = expInstQ.pop_front();
                    checkOutput("inst_pc", inst_pc, expPc);
                    checkOutput("inst", inst, memWord(expPc));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        nVectors       = 0;
        nMiscompares   = 0;
        deliveredCount = 0;
        rspDelay       = 0;
        rst            = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        checkOutput("rst_rsp_ready", {31'b0, imem_rsp_ready}, 32'd0);
        checkOutput("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
        checkOutput("rst_req_addr", imem_req_addr, 32'd0);
        checkOutput("rst_inst", inst, 32'd0);
        checkOutput("rst_inst_pc", inst_pc, 32'd0);

        // Zero-wait streaming from the reset vector.
        expReqQ.push_back(32'h8000_0000); expInstQ.push_back(32'h8000_0000);
        expReqQ.push_back(32'h8000_0004); expInstQ.push_back(32'h8000_0004);
        expReqQ.push_back(32'h8000_0008); expInstQ.push_back(32'h8000_0008);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("idle_req_valid", {31'b0, imem_req_valid}, 32'd0);
        @(negedge clk);
        checkOutput("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
        checkOutput("first_req_addr", imem_req_addr, 32'h8000_0000);
        streamUntil(3, "stream_reset");
        checkOutput("spacing_0_1", deliverCycle[1] - deliverCycle[0], 32'd3);
        checkOutput("spacing_1_2", deliverCycle[2] - deliverCycle[1], 32'd3);

        // Decode stalls for 5 cycles while the slot is full.
        expReqQ.push_back(32'h8000_000C); expInstQ.push_back(32'h8000_000C);
        inst_ready     = 1'b0;
        imem_req_ready = 1'b1;
        waitInstValid("stall_fill");
        imem_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_inst_valid", {31'b0, inst_valid}, 32'd1);
            checkOutput("stall_inst_pc", inst_pc, 32'h8000_000C);
            checkOutput("stall_inst", inst, memWord(32'h8000_000C));
            checkOutput("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
            @(posedge clk); #1;
        end
        inst_ready = 1'b1;
        streamUntil(4, "stall_release");

        // Redirect to an unaligned target while a slow response is pending.
        expReqQ.push_back(32'h8000_0010);
        expReqQ.push_back(32'h8000_0100); expInstQ.push_back(32'h8000_0100);
        expReqQ.push_back(32'h8000_0104); expInstQ.push_back(32'h8000_0104);
        rspDelay       = 2;
        imem_req_ready = 1'b1;
        waitRspReady("redir_wait_enter");
        imem_req_ready = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h8000_0103, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        rspDelay = 0;
        streamUntil(6, "redir_wait_stream");

        // Redirect in OUT with decode accepting, then memory backpressure.
        expReqQ.push_back(32'h8000_0108); expInstQ.push_back(32'h8000_0108);
        expReqQ.push_back(32'h8000_0200); expInstQ.push_back(32'h8000_0200);
        imem_req_ready = 1'b1;
        waitInstValid("redir_out_fill");
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h8000_0200, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            checkOutput("bp_req_valid", {31'b0, imem_req_valid}, 32'd1);
            checkOutput("bp_req_addr", imem_req_addr, 32'h8000_0200);
            @(posedge clk); #1;
        end
        streamUntil(8, "redir_out_stream");

        // Halt while a fetch is in flight: it is still delivered, then nothing.
        expReqQ.push_back(32'h8000_0204); expInstQ.push_back(32'h8000_0204);
        rspDelay       = 2;
        imem_req_ready = 1'b1;
        waitRspReady("halt_wait_enter");
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        @(posedge clk); #1;
        halt     = 1'b0;
        rspDelay = 0;
        streamUntil(9, "halt_drain");
        imem_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checkOutput("halt_no_req", {31'b0, imem_req_valid}, 32'd0);
            checkOutput("halt_no_inst", {31'b0, inst_valid}, 32'd0);
            @(posedge clk); #1;
        end
        imem_req_ready = 1'b0;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
        end
        expReqQ.push_back(32'h8000_0000); expInstQ.push_back(32'h8000_0000);
        rst = 1'b0;
        streamUntil(10, "halt_restart");

        // Wrap-around: redirect in REQ kills the held request, then fetch FFFF_FFFC and 0.
        expReqQ.push_back(32'h8000_0004);
        expReqQ.push_back(32'hFFFF_FFFC); expInstQ.push_back(32'hFFFF_FFFC);
        expReqQ.push_back(32'h0000_0000); expInstQ.push_back(32'h0000_0000);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        streamUntil(12, "wrap_stream");

        checkOutput("req_queue_drained", expReqQ.size(), 32'd0);
        checkOutput("inst_queue_drained", expInstQ.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
